// File: rtl/arith8_sweep_ctrl.sv
// Sweep sequencer for the 8-bit arithmetic core: add, sub, div, mul on one operand pair.
// Optional divide-by-zero flagging is enabled with `define ARITH8_DIVZ_CHECK_EN.
module arith8_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din_a,
  input  logic [7:0] din_b,
  input  logic [7:0] core_y,
  output logic [7:0] core_a,
  output logic [7:0] core_b,
  output logic [1:0] core_sel,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [1:0] res_op,
  output logic       res_err,
  output logic       done
);

  // Counter holds remaining SETTLE cycles minus one; a setting of 0 acts as 1.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] core_a_q, core_a_d;
  logic [7:0] core_b_q, core_b_d;
  logic [1:0] core_sel_q, core_sel_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic [1:0] res_op_q, res_op_d;
  logic       res_err_q, res_err_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_sel_d  = core_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          core_a_d   = din_a;
          core_b_d   = din_b;
          core_sel_d = 2'd0;
          cnt_d      = SETTLE_LOAD;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
`ifdef ARITH8_DIVZ_CHECK_EN
          if (core_sel_q == 2'd2 && core_b_q == '0) begin
            res_data_d = 8'hFF;
            res_err_d  = 1'b1;
          end else begin
            res_data_d = core_y;
            res_err_d  = 1'b0;
          end
`else
          res_data_d = core_y;
          res_err_d  = 1'b0;
`endif
          res_op_d    = core_sel_q;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (core_sel_q != 2'd3) begin
            core_sel_d = core_sel_q + 2'd1;
            cnt_d      = SETTLE_LOAD;
            state_d    = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_sel_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_sel_q  <= core_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
      done_q      <= done_d;
    end
  end

  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign core_sel  = core_sel_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_arith8_sweep_ctrl.sv
// Directed bench for arith8_sweep_ctrl: sweeps, backpressure, busy-start, reset, long settle.
module tb_arith8_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, res_ready, busy, res_valid, res_err, done;
  logic [7:0] din_a, din_b, core_y, core_a, core_b, res_data;
  logic [1:0] core_sel, res_op;

  logic       start3, res_ready3, busy3, res_valid3, res_err3, done3;
  logic [7:0] din_a3, din_b3, core_y3, core_a3, core_b3, res_data3;
  logic [1:0] core_sel3, res_op3;

`ifdef ARITH8_DIVZ_CHECK_EN
  localparam logic [7:0] DIVZ_D = 8'hFF;
  localparam logic       DIVZ_E = 1'b1;
`else
  localparam logic [7:0] DIVZ_D = 8'hEE;
  localparam logic       DIVZ_E = 1'b0;
`endif

  // Behavioural arithmetic core; divide by zero returns 8'hEE.
  function automatic logic [7:0] core_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return (b == 8'd0) ? 8'hEE : a / b;
      default: return a * b;
    endcase
  endfunction

  assign core_y  = core_fn(core_a, core_b, core_sel);
  assign core_y3 = core_fn(core_a3, core_b3, core_sel3);

  arith8_sweep_ctrl #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_a(din_a), .din_b(din_b),
    .core_y(core_y), .core_a(core_a), .core_b(core_b), .core_sel(core_sel),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_err(res_err), .done(done)
  );

  arith8_sweep_ctrl #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .din_a(din_a3), .din_b(din_b3),
    .core_y(core_y3), .core_a(core_a3), .core_b(core_b3), .core_sel(core_sel3),
    .busy(busy3), .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_op(res_op3), .res_err(res_err3), .done(done3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack1();
    return {busy, done, core_a, core_b, core_sel, res_valid, res_data, res_op, res_err};
  endfunction

  function automatic logic [31:0] pack3();
    return {busy3, done3, core_a3, core_b3, core_sel3, res_valid3, res_data3, res_op3, res_err3};
  endfunction

  // One full sweep on the SETTLE_CYC=1 instance; exp_d holds op0 in the low byte.
  task automatic do_sweep(input logic [7:0] a, input logic [7:0] b, input logic [31:0] exp_d,
                          input logic [3:0] exp_e, input int stall, input bit poke);
    din_a = a; din_b = b; start = 1'b1; res_ready = (stall == 0);
    tick;
    start = 1'b0; din_a = ~a; din_b = ~b;
    check("busy_on", {31'd0, busy}, 32'd1);
    check("core_a_lat", {24'd0, core_a}, {24'd0, a});
    check("core_b_lat", {24'd0, core_b}, {24'd0, b});
    check("sel_init", {30'd0, core_sel}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (poke && i == 1) begin
        start = 1'b1; din_a = 8'h77; din_b = 8'h55;
      end
      tick;
      start = 1'b0;
      check("valid_up", {31'd0, res_valid}, 32'd1);
      check("res_op", {30'd0, res_op}, i);
      check("res_data", {24'd0, res_data}, {24'd0, exp_d[8*i +: 8]});
      check("res_err", {31'd0, res_err}, {31'd0, exp_e[i]});
      check("core_a_hold", {24'd0, core_a}, {24'd0, a});
      for (int k = 0; k < stall; k++) begin
        tick;
        check("stall_valid", {31'd0, res_valid}, 32'd1);
        check("stall_data", {24'd0, res_data}, {24'd0, exp_d[8*i +: 8]});
        check("stall_op", {30'd0, res_op}, i);
      end
      res_ready = 1'b1;
      tick;
      res_ready = (stall == 0);
      check("valid_down", {31'd0, res_valid}, 32'd0);
      if (i < 3) begin
        check("sel_next", {30'd0, core_sel}, i + 1);
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("done_mid", {31'd0, done}, 32'd0);
      end else begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_off", {31'd0, busy}, 32'd0);
      end
    end
    res_ready = 1'b0;
    tick;
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    start = 0; din_a = 0; din_b = 0; res_ready = 0;
    start3 = 0; din_a3 = 0; din_b3 = 0; res_ready3 = 0;

    repeat (2) tick;
    check("rst_outs", pack1(), 32'd0);
    check("rst_outs3", pack3(), 32'd0);
    rst_n = 1'b1;
    tick;

    // Basic sweep: 0C+03, 0C-03, 0C/03, 0C*03
    do_sweep(8'h0C, 8'h03, 32'h24_04_09_0F, 4'b0000, 0, 1'b0);
    // Backpressure of 5 cycles per result
    do_sweep(8'h0C, 8'h03, 32'h24_04_09_0F, 4'b0000, 5, 1'b0);
    // Divide by zero
    do_sweep(8'h05, 8'h00, {8'h00, DIVZ_D, 8'h05, 8'h05}, {1'b0, DIVZ_E, 2'b00}, 0, 1'b0);
    // Start while busy is ignored and not queued
    do_sweep(8'h0C, 8'h03, 32'h24_04_09_0F, 4'b0000, 0, 1'b1);
    repeat (3) begin
      tick;
      check("no_requeue_valid", {31'd0, res_valid}, 32'd0);
      check("no_requeue_busy", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset during op-1 SETTLE
    din_a = 8'h0C; din_b = 8'h03; start = 1'b1; res_ready = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("pre_rst_sel", {30'd0, core_sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", pack1(), 32'd0);
    tick;
    check("rst_hold", pack1(), 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b0;
    tick;
    do_sweep(8'h0C, 8'h03, 32'h24_04_09_0F, 4'b0000, 0, 1'b0);

    // SETTLE_CYC=3 instance
    din_a3 = 8'h0C; din_b3 = 8'h03; start3 = 1'b1; res_ready3 = 1'b1;
    tick;
    start3 = 1'b0;
    check("s3_busy", {31'd0, busy3}, 32'd1);
    tick;
    check("s3_e1", {31'd0, res_valid3}, 32'd0);
    tick;
    check("s3_e2", {31'd0, res_valid3}, 32'd0);
    tick;
    check("s3_e3", {31'd0, res_valid3}, 32'd1);
    check("s3_op0", {30'd0, res_op3}, 32'd0);
    check("s3_d0", {24'd0, res_data3}, 32'h0F);
    tick;
    check("s3_e4", {31'd0, res_valid3}, 32'd0);
    check("s3_sel1", {30'd0, core_sel3}, 32'd1);
    tick;
    check("s3_e5", {31'd0, res_valid3}, 32'd0);
    tick;
    check("s3_e6", {31'd0, res_valid3}, 32'd0);
    tick;
    check("s3_e7", {31'd0, res_valid3}, 32'd1);
    check("s3_op1", {30'd0, res_op3}, 32'd1);
    check("s3_d1", {24'd0, res_data3}, 32'h09);
    begin
      int n;
      n = 0;
      while (!done3 && n < 30) begin
        tick;
        n++;
      end
      check("s3_done", {31'd0, done3}, 32'd1);
      check("s3_done_cyc", n, 32'd9);
      check("s3_busy_off", {31'd0, busy3}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith8_sweep_ctrl.md
# arith8_sweep_ctrl

Sequencing front-end that sits directly upstream of the 8-bit arithmetic core. It captures one operand pair, holds it on the core's `a`/`b` inputs, and steps the core's operation select through add, sub, div, mul. After a programmable settle time it samples each 8-bit core result. Results stream out one at a time over a valid/ready handshake, tagged with their operation code, so a display or UART stage can consume the full four-result sweep.

## Interface
- `SETTLE_CYC`, default 1: cycles the core output settles after operands/select change before sampling; legal range 1..15; 0 behaves as 1.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `start` in 1: begin sweep; sampled only in IDLE.
- `din_a` in 8: operand A, latched on accepted `start`.
- `din_b` in 8: operand B, latched on accepted `start`.
- `core_y` in 8: result from the arithmetic core.
- `core_a` out 8: registered operand A to the core.
- `core_b` out 8: registered operand B to the core.
- `core_sel` out 2: registered op select; 0 add, 1 sub, 2 div, 3 mul.
- `busy` out 1: high from accepted `start` until sweep completes.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 8: captured result.
- `res_op` out 2: op code of `res_data`.
- `res_err` out 1: divide-by-zero flag (see Configuration).
- `done` out 1: one-cycle pulse after last result accepted.

## Operation
- States:
  - IDLE: `busy` = 0. On `start` = 1: latch `din_a`/`din_b` into `core_a`/`core_b`, set `core_sel` = 0, load the settle counter, go to SETTLE.
  - SETTLE: lasts exactly `SETTLE_CYC` cycles. At the edge ending the last SETTLE cycle: register `core_y` into `res_data` and `core_sel` into `res_op`, set `res_valid` = 1, go to OUT.
  - OUT: `res_valid`, `res_data`, `res_op`, `res_err` held stable until handshake.
    - Handshake occurs on an edge where `res_valid` & `res_ready`.
    - If `core_sel` < 3: increment `core_sel`, clear `res_valid`, reload counter, go to SETTLE.
    - If `core_sel` = 3: clear `res_valid`, go to IDLE, assert `done` for the next cycle.
- `core_a`/`core_b` are constant for the whole sweep; `din_a`/`din_b` are ignored while `busy`.
- `start` while `busy` is ignored and not queued.
- `start` in the cycle `done` is high is accepted, since the FSM is in IDLE.
- `res_ready` outside OUT has no effect.
- `busy` is high in SETTLE and OUT and low in IDLE; it drops on the same edge that raises `done`.
- Reset, including mid-sweep: FSM to IDLE and the partial sweep is discarded. Every output resets to 0:
  - `busy`, `done`
  - `core_a`, `core_b`, `core_sel`
  - `res_valid`, `res_data`, `res_op`, `res_err`

## Timing
- `start` sampled at edge E0 → `res_valid` rises at edge E0+`SETTLE_CYC`.
- Per result, with `res_ready` held high: 1 OUT cycle + `SETTLE_CYC` SETTLE cycles.
- Full sweep with `SETTLE_CYC` = 1 and `res_ready` = 1:
  - `res_valid` rises at E1, E3, E5, E7.
  - Handshakes occur at E2, E4, E6, E8.
  - `done` is high in the cycle after E8.
- Backpressure stalls the sweep indefinitely with no result loss.
- No combinational path from `res_ready` to any output.

## Configuration
- Macro `ARITH8_DIVZ_CHECK_EN`.
- Defined:
  - On capture with `core_sel` = 2 and `core_b` = 0: `res_err` = 1 and `res_data` = 8'hFF.
  - All other captures: `res_err` = 0 and `res_data` = `core_y`.
- Undefined: `res_err` tied to 0; `res_data` is always `core_y`.

## Test plan
- a=8'h0C, b=8'h03, `start` pulse, `res_ready`=1, `SETTLE_CYC`=1 → four results (op,data): (0,8'h0F), (1,8'h09), (2,8'h04), (3,8'h24) at E1/E3/E5/E7; `done` pulses after E8; `busy` low after E8.
- Same operands, `res_ready` low for 5 cycles at each result → data and op held stable while stalled; no drop or duplicate; sequence unchanged.
- a=8'h05, b=8'h00, macro defined → op-2 result has `res_err`=1, `res_data`=8'hFF. Macro undefined → `res_err`=0, data equals `core_y`.
- Second `start` with a different `din_a` while `busy` → ignored; `core_a` unchanged; exactly four results, then one `done`.
- `rst_n` low during op-1 SETTLE → all outputs 0 immediately (async); after release, a new `start` sweeps from op 0.
- `SETTLE_CYC`=3, `start` at E0 → first `res_valid` at E3; subsequent results 4 cycles apart with `res_ready`=1.
